// File: rtl/mem_pkg.sv
// Shared data-memory parameters and the store-buffer entry payload.
// Used by store_buffer and sb_cam for bus widths and default sizing.
package mem_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned SB_DEPTH = 4;

    // Highest valid word address of the data memory.
    localparam logic [ADDR_W-1:0] SB_ADDR_MAX = 32'h0000_FFFF;

    // One pending store: {addr, data}.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_cam.sv
// Address-match array for the store buffer.
// Ports:
//   key    in   lookup address (CPU address this cycle)
//   addrs  in   address field of every buffer slot
//   valid  in   per-slot valid bits
//   hit    out  any valid slot matches key
//   match  out  one-hot vector of matching slots (at most one bit set)
module sb_cam
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic [ADDR_W-1:0] key,
    input  logic [ADDR_W-1:0] addrs [DEPTH],
    input  logic [DEPTH-1:0]  valid,
    output logic              hit,
    output logic [DEPTH-1:0]  match
);

    // Compare key against every slot; invalid slots never match.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (addrs[i] == key);
        end
    end

    assign hit = |match;

endmodule

// File: rtl/store_buffer.sv
// Coalescing store buffer between a CPU and a single-ported data memory.
// Stores are queued and drained to memory when the port is free; loads
// that hit a pending store are served from the buffer, load misses go
// straight to memory.
// Ports:
//   CK, RST_N                 clock, async active-low reset
//   CpuAddress/CpuWriteData   CPU word address and store data
//   CpuMemWrite/CpuMemRead    CPU store / load request (both = store)
//   Flush                     force a drain whenever the port is free
//   CpuReadData               load data (combinational)
//   Address/WriteData         data-memory address and write data
//   MemWrite/MemRead          data-memory strobes (never both high)
//   ReadData                  data-memory read data
//   Empty, Count              buffer occupancy status
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned       DEPTH    = SB_DEPTH,
    parameter logic [ADDR_W-1:0] ADDR_MAX = SB_ADDR_MAX
) (
    input  logic                   CK,
    input  logic                   RST_N,
    input  logic [ADDR_W-1:0]      CpuAddress,
    input  logic [DATA_W-1:0]      CpuWriteData,
    input  logic                   CpuMemWrite,
    input  logic                   CpuMemRead,
    input  logic                   Flush,
    output logic [DATA_W-1:0]      CpuReadData,
    output logic [ADDR_W-1:0]      Address,
    output logic [DATA_W-1:0]      WriteData,
    output logic                   MemWrite,
    output logic                   MemRead,
    input  logic [DATA_W-1:0]      ReadData,
    output logic                   Empty,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t          entry_q [DEPTH];
    sb_entry_t          entry_d [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [ADDR_W-1:0]  entry_addr [DEPTH];
    logic               hit;
    logic [DEPTH-1:0]   match;
    logic [DATA_W-1:0]  hit_data;

    logic               is_store;
    logic               is_load;
    logic               no_access;
    logic               in_range;
    logic               store_ok;
    logic               port_busy;
    logic               is_empty;
    logic               is_full;
    logic               drain;
    logic               coalesce;
    logic               enqueue;

    // Address view of the slots for the CAM.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_addr[i] = entry_q[i].addr;
        end
    end

    sb_cam #(
        .DEPTH (DEPTH)
    ) u_cam (
        .key   (CpuAddress),
        .addrs (entry_addr),
        .valid (valid_q),
        .hit   (hit),
        .match (match)
    );

    // Data of the single matching slot (one-hot OR mux).
    always_comb begin
        hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                hit_data = hit_data | entry_q[i].data;
            end
        end
    end

    // Request decode and drain / coalesce / enqueue decisions.
    always_comb begin
        is_store  = CpuMemWrite;
        is_load   = CpuMemRead & ~CpuMemWrite;
        no_access = ~CpuMemWrite & ~CpuMemRead;
        in_range  = (CpuAddress <= ADDR_MAX);
        store_ok  = is_store & in_range;
        port_busy = is_load & ~hit;
        is_empty  = (count_q == '0);
        is_full   = (count_q == CNT_W'(DEPTH));
        // A full buffer makes room for a new (non-coalescing) store by
        // draining its head in the same cycle, so stores never stall.
        drain     = ~is_empty & ~port_busy
                  & (no_access | Flush | (store_ok & ~hit & is_full));
        // A hit on the head that is leaving this cycle cannot be merged.
        coalesce  = store_ok & hit & ~(drain & match[head_q]);
        enqueue   = store_ok & ~coalesce;
    end

    // Memory-side and CPU-side outputs.
    always_comb begin
        MemWrite    = drain;
        MemRead     = port_busy;
        Address     = drain ? entry_q[head_q].addr : CpuAddress;
        WriteData   = drain ? entry_q[head_q].data : '0;
        CpuReadData = (is_load & hit) ? hit_data : ReadData;
        Empty       = is_empty;
        Count       = count_q;
    end

    // FIFO next state: pop at head, merge in place, push at tail.
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (coalesce && match[i]) begin
                entry_d[i].data = CpuWriteData;
            end
        end

        // On a full store tail == head, so the push reuses the slot just popped.
        if (enqueue) begin
            entry_d[tail_q].addr = CpuAddress;
            entry_d[tail_q].data = CpuWriteData;
            valid_d[tail_q]      = 1'b1;
            tail_d               = tail_q + PTR_W'(1);
        end

        case ({enqueue, drain})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared by reset; pending stores are discarded.
    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload storage; never visible unless its valid bit is set.
    always_ff @(posedge CK) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] AMAX  = 32'h0000_FFFF;

    logic        CK = 1'b0;
    logic        RST_N;
    logic [31:0] CpuAddress;
    logic [31:0] CpuWriteData;
    logic        CpuMemWrite;
    logic        CpuMemRead;
    logic        Flush;
    logic [31:0] CpuReadData;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Empty;
    logic [2:0]  Count;

    store_buffer #(
        .DEPTH    (DEPTH),
        .ADDR_MAX (AMAX)
    ) dut (
        .CK           (CK),
        .RST_N        (RST_N),
        .CpuAddress   (CpuAddress),
        .CpuWriteData (CpuWriteData),
        .CpuMemWrite  (CpuMemWrite),
        .CpuMemRead   (CpuMemRead),
        .Flush        (Flush),
        .CpuReadData  (CpuReadData),
        .Address      (Address),
        .WriteData    (WriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .ReadData     (ReadData),
        .Empty        (Empty),
        .Count        (Count)
    );

    always #5 CK = ~CK;

    // Memory read data is a fixed function of the address.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
    endfunction

    assign ReadData = rd_fn(Address);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mem_cell [256];
    int          total = 0;
    int          bad   = 0;

    logic        e_drain;
    logic        e_busy;
    logic        e_coal;
    int          e_idx;
    logic [31:0] e_rdata;

    // Expected behaviour of the current cycle from the queue contents.
    task automatic model_eval();
        logic ld, st, inr, idle;
        ld   = CpuMemRead && !CpuMemWrite;
        st   = CpuMemWrite;
        inr  = (CpuAddress <= AMAX);
        idle = !CpuMemWrite && !CpuMemRead;
        e_idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].addr == CpuAddress) e_idx = i;
        end
        e_busy  = ld && (e_idx < 0);
        e_drain = (q.size() > 0) && !e_busy &&
                  (idle || Flush || (st && inr && (e_idx < 0) && (q.size() == int'(DEPTH))));
        e_coal  = st && inr && (e_idx >= 0) && !(e_drain && (e_idx == 0));
        e_rdata = (e_idx >= 0) ? q[e_idx].data : rd_fn(CpuAddress);
    endtask

    task automatic model_commit();
        ent_t e;
        if (e_drain) void'(q.pop_front());
        if (e_coal) begin
            if (e_drain) q[e_idx - 1].data = CpuWriteData;
            else         q[e_idx].data     = CpuWriteData;
        end else if (CpuMemWrite && (CpuAddress <= AMAX)) begin
            e.addr = CpuAddress;
            e.data = CpuWriteData;
            q.push_back(e);
        end
    endtask

    task automatic apply(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, input logic fl);
        @(negedge CK);
        CpuMemWrite  = we;
        CpuMemRead   = re;
        CpuAddress   = a;
        CpuWriteData = d;
        Flush        = fl;
        #2;
        model_eval();
    endtask

    task automatic commit();
        if (MemWrite === 1'b1 && Address < 256) mem_cell[Address[7:0]] = WriteData;
        @(posedge CK);
        model_commit();
        #1;
    endtask

    task automatic drain_all();
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            commit();
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b1; CpuMemWrite = 1'b0; CpuMemRead = 1'b0;
        CpuAddress = '0; CpuWriteData = '0; Flush = 1'b0;
        #1 RST_N = 1'b0;
        #2;
        total++; if (Count !== 3'd0)    begin bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
        total++; if (Empty !== 1'b1)    begin bad++; $display("FAIL reset_empty got=%b exp=1", Empty); end
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL reset_memwrite got=%b exp=0", MemWrite); end
        total++; if (MemRead !== 1'b0)  begin bad++; $display("FAIL reset_memread got=%b exp=0", MemRead); end
        q.delete();
        @(negedge CK);
        RST_N = 1'b1;
    endtask

    task automatic test_drain_idle();
        apply(1'b1, 1'b0, 32'h10, 32'hAAAA, 1'b0);
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL idle_store_nodrain got=%b exp=0", MemWrite); end
        commit();
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL idle_count1 got=%0d exp=1", Count); end
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (MemWrite !== 1'b1)       begin bad++; $display("FAIL idle_memwrite got=%b exp=1", MemWrite); end
        total++; if (Address !== 32'h10)      begin bad++; $display("FAIL idle_addr got=%h exp=10", Address); end
        total++; if (WriteData !== 32'hAAAA)  begin bad++; $display("FAIL idle_wdata got=%h exp=aaaa", WriteData); end
        commit();
        total++; if (mem_cell[8'h10] !== 32'hAAAA) begin bad++; $display("FAIL idle_memcell got=%h exp=aaaa", mem_cell[8'h10]); end
        total++; if (Empty !== 1'b1) begin bad++; $display("FAIL idle_empty got=%b exp=1", Empty); end
    endtask

    task automatic test_coalesce();
        apply(1'b1, 1'b0, 32'h20, 32'h1, 1'b0); commit();
        apply(1'b1, 1'b0, 32'h20, 32'h2, 1'b0); commit();
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL coal_count got=%0d exp=1", Count); end
        apply(1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
        total++; if (CpuReadData !== 32'h2) begin bad++; $display("FAIL coal_rdata got=%h exp=2", CpuReadData); end
        total++; if (MemRead !== 1'b0)      begin bad++; $display("FAIL coal_memread got=%b exp=0", MemRead); end
        commit();
        drain_all();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            apply(1'b1, 1'b0, 32'(k), 32'h100 + 32'(k), 1'b0);
            total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL full_fill_nodrain%0d got=%b exp=0", k, MemWrite); end
            commit();
        end
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL full_count4 got=%0d exp=4", Count); end
        apply(1'b1, 1'b0, 32'h4, 32'h104, 1'b0);
        total++; if (MemWrite !== 1'b1)     begin bad++; $display("FAIL full_drain got=%b exp=1", MemWrite); end
        total++; if (Address !== 32'h0)     begin bad++; $display("FAIL full_addr got=%h exp=0", Address); end
        total++; if (WriteData !== 32'h100) begin bad++; $display("FAIL full_wdata got=%h exp=100", WriteData); end
        commit();
        total++; if (Count !== 3'd4) begin bad++; $display("FAIL full_count_kept got=%0d exp=4", Count); end
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (MemWrite !== 1'b1)     begin bad++; $display("FAIL full_next_drain got=%b exp=1", MemWrite); end
        total++; if (Address !== 32'h1)     begin bad++; $display("FAIL full_next_addr got=%h exp=1", Address); end
        total++; if (WriteData !== 32'h101) begin bad++; $display("FAIL full_next_wdata got=%h exp=101", WriteData); end
        commit();
        total++; if (Count !== 3'd3) begin bad++; $display("FAIL full_count3 got=%0d exp=3", Count); end
        drain_all();
    endtask

    task automatic test_miss_flush();
        apply(1'b1, 1'b0, 32'h5, 32'h55, 1'b0); commit();
        apply(1'b0, 1'b1, 32'h9, 32'h0, 1'b1);
        total++; if (MemRead !== 1'b1)        begin bad++; $display("FAIL miss_memread got=%b exp=1", MemRead); end
        total++; if (Address !== 32'h9)       begin bad++; $display("FAIL miss_addr got=%h exp=9", Address); end
        total++; if (MemWrite !== 1'b0)       begin bad++; $display("FAIL miss_nodrain got=%b exp=0", MemWrite); end
        total++; if (CpuReadData !== rd_fn(32'h9)) begin bad++; $display("FAIL miss_rdata got=%h exp=%h", CpuReadData, rd_fn(32'h9)); end
        commit();
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL miss_count got=%0d exp=1", Count); end
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (MemWrite !== 1'b1)  begin bad++; $display("FAIL miss_then_drain got=%b exp=1", MemWrite); end
        total++; if (Address !== 32'h5)  begin bad++; $display("FAIL miss_then_addr got=%h exp=5", Address); end
        commit();
        total++; if (Empty !== 1'b1) begin bad++; $display("FAIL miss_empty got=%b exp=1", Empty); end
    endtask

    task automatic test_out_of_range();
        apply(1'b1, 1'b0, 32'h7, 32'h77, 1'b0); commit();
        apply(1'b1, 1'b0, 32'h1_0000, 32'hDEAD, 1'b0);
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL oor_nodrain got=%b exp=0", MemWrite); end
        commit();
        total++; if (Count !== 3'd1) begin bad++; $display("FAIL oor_count got=%0d exp=1", Count); end
        apply(1'b0, 1'b1, 32'h1_0000, 32'h0, 1'b0);
        total++; if (MemRead !== 1'b1) begin bad++; $display("FAIL oor_load_memread got=%b exp=1", MemRead); end
        total++; if (CpuReadData !== rd_fn(32'h1_0000)) begin bad++; $display("FAIL oor_load_rdata got=%h exp=%h", CpuReadData, rd_fn(32'h1_0000)); end
        commit();
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (MemWrite !== 1'b1) begin bad++; $display("FAIL oor_drain7 got=%b exp=1", MemWrite); end
        total++; if (Address !== 32'h7) begin bad++; $display("FAIL oor_drain7_addr got=%h exp=7", Address); end
        commit();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL oor_no_write%0d got=%b exp=0 addr=%h", i, MemWrite, Address); end
            commit();
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, 32'h30 + 32'(k), 32'hC0 + 32'(k), 1'b0);
            commit();
        end
        total++; if (Count !== 3'd3) begin bad++; $display("FAIL arst_count3 got=%0d exp=3", Count); end
        apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        RST_N = 1'b0;
        #1;
        total++; if (Count !== 3'd0)    begin bad++; $display("FAIL arst_count got=%0d exp=0", Count); end
        total++; if (Empty !== 1'b1)    begin bad++; $display("FAIL arst_empty got=%b exp=1", Empty); end
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL arst_memwrite got=%b exp=0", MemWrite); end
        q.delete();
        @(negedge CK);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL arst_post_write%0d got=%b exp=0", i, MemWrite); end
            commit();
        end
    endtask

    task automatic test_random();
        logic        we, re, fl;
        logic [31:0] a, d;
        for (int n = 0; n < 600; n++) begin
            we = ($urandom_range(0, 2) == 0);
            re = ($urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 5) == 0);
            a  = ($urandom_range(0, 15) == 0) ? 32'h1_0000 + 32'($urandom_range(0, 3))
                                               : 32'($urandom_range(0, 7));
            d  = $urandom;
            apply(we, re, a, d, fl);
            total++; if (MemWrite !== e_drain) begin bad++; $display("FAIL rnd_memwrite n=%0d got=%b exp=%b", n, MemWrite, e_drain); end
            total++; if (MemRead !== e_busy)   begin bad++; $display("FAIL rnd_memread n=%0d got=%b exp=%b", n, MemRead, e_busy); end
            total++; if (MemWrite === 1'b1 && MemRead === 1'b1) begin bad++; $display("FAIL rnd_both_strobes n=%0d got=11 exp=not-both", n); end
            total++; if (Empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_empty n=%0d got=%b exp=%b", n, Empty, q.size() == 0); end
            if (e_drain) begin
                total++; if (Address !== q[0].addr)   begin bad++; $display("FAIL rnd_drain_addr n=%0d got=%h exp=%h", n, Address, q[0].addr); end
                total++; if (WriteData !== q[0].data) begin bad++; $display("FAIL rnd_drain_data n=%0d got=%h exp=%h", n, WriteData, q[0].data); end
            end
            if (e_busy) begin
                total++; if (Address !== a) begin bad++; $display("FAIL rnd_miss_addr n=%0d got=%h exp=%h", n, Address, a); end
            end
            if (re && !we) begin
                total++; if (CpuReadData !== e_rdata) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, CpuReadData, e_rdata); end
            end
            commit();
            total++; if (Count !== 3'(q.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, Count, q.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_drain_idle();
        test_coalesce();
        test_full();
        test_miss_flush();
        test_out_of_range();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_MAX, default 32'h0000FFFF, highest valid word address of the data memory.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, ports named as follows:
- CK  in  1  clock; all state updates on posedge.
- RST_N  in  1  asynchronous, active-low reset.
REQ-004 SHALL have these CPU-side ports:
- CpuAddress  in  32  word address of the load or store.
- CpuWriteData  in  32  store data.
- CpuMemWrite  in  1  store request this cycle.
- CpuMemRead  in  1  load request this cycle.
- Flush  in  1  drain request.
- CpuReadData  out  32  load data, combinational.
REQ-005 SHALL have these memory-side ports:
- Address  out  32  data-memory address.
- WriteData  out  32  data-memory write data.
- MemWrite  out  1  data-memory write strobe.
- MemRead  out  1  data-memory read strobe.
- ReadData  in  32  data-memory read data.
REQ-006 SHALL have these status ports:
- Empty  out  1  no pending entries.
- Count  out  $clog2(DEPTH)+1  number of pending entries.

Function
REQ-007 SHALL hold pending stores in a FIFO of {addr, data}, oldest at head.
REQ-008 SHALL treat CpuMemWrite=1 with CpuMemRead=1 as a store only.
REQ-009 SHALL ignore a store whose CpuAddress > ADDR_MAX: no enqueue and no state change.
REQ-010 SHALL report a hit when CpuAddress equals the address of any valid entry; coalescing guarantees at most one match.
REQ-011 SHALL, for a valid store that hits an entry other than a head being drained this cycle, overwrite that entry's data at posedge with Count unchanged (coalescing).
REQ-012 SHALL otherwise enqueue a valid store at the tail at posedge.
REQ-013 SHALL define port_busy = CpuMemRead & ~CpuMemWrite & ~hit, i.e. a load miss owns the memory port.
REQ-014 SHALL drain the head (MemWrite=1, Address=head addr, WriteData=head data, pop at posedge) when ~Empty & ~port_busy and any of the following holds:
- no CPU access this cycle;
- Flush=1;
- a non-coalescing valid store arrives while Count==DEPTH.
REQ-015 SHALL, on a full store, dequeue and enqueue in the same cycle, so Count stays DEPTH and no store is ever lost or stalled.
REQ-016 SHALL, on a load hit, drive CpuReadData = matching entry data with MemRead=0; on a load miss, drive MemRead=1, Address=CpuAddress, CpuReadData=ReadData.
REQ-017 SHALL drive MemWrite=0 when not draining and MemRead=0 when not a load miss; MemRead and MemWrite are never both 1.
REQ-018 SHALL pass out-of-range loads through to memory unmodified (CpuReadData=ReadData).
REQ-019 SHALL wrap head and tail pointers modulo DEPTH.

Reset
REQ-020 SHALL, on RST_N=0 and asynchronously, clear all pointers and valid bits so that Count=0, Empty=1 and MemWrite=0; pending stores are discarded.
REQ-021 SHALL leave entry data uninitialised after reset; it is never observable.

Structure
REQ-022 SHALL take ADDR_MAX default and DEPTH default from shared package mem_pkg.
REQ-023 SHALL place the address-match logic in sub-module sb_cam, which outputs a hit flag and a one-hot match vector.

Verification
REQ-024 SHALL check: store 0x10<-0xAAAA, then an idle cycle -> MemWrite=1, Address=0x10, WriteData=0xAAAA; memory cell 0x10=0xAAAA; Empty=1.
REQ-025 SHALL check: store 0x20<-1, then store 0x20<-2 back-to-back -> Count=1; load 0x20 returns 2 with MemRead=0.
REQ-026 SHALL check: 4 stores to 0x0..0x3, then a 5th store to 0x4 -> head 0x0 drains the same cycle and Count stays 4; a following idle cycle drains address 0x1.
REQ-027 SHALL check: buffer holds 0x5, load 0x9 (miss) with Flush=1 -> MemRead=1, Address=0x9, no drain that cycle; the next cycle drains 0x5.
REQ-028 SHALL check: store to 0x10000 -> Count unchanged and no MemWrite ever issued for it.
REQ-029 SHALL check: RST_N asserted low with Count=3 -> Count=0 and Empty=1 immediately, with no drain after release.
